// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// States, bubble instruction and default reset PC.
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_C  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP     = 32'd4;

endpackage

// File: rtl/fetch_perf_counter.sv
// Fetch performance counters: retired fetches and bubble cycles.
// Built only when FETCH_PERF_CNT_EN is defined.
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc,
    input  logic        bubble_inc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
);

    // free-running wrap counters, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (fetch_inc)
                perf_fetched <= perf_fetched + 32'd1;
            if (bubble_inc)
                perf_bubbles <= perf_bubbles + 32'd1;
        end
    end

endmodule
`endif

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, single-outstanding imem fetch, stall/redirect.
// Optional perf counters with FETCH_PERF_CNT_EN.
module instruction_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_C,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_IF,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] INSTR_IF,
    output logic [31:0] PC_IF,
    output logic        fetch_busy
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  buf_q, buf_d;
    logic [31:0]  pc_inc;
    logic [31:0]  word;
    logic         word_vld;
    logic         consume;

    assign pc_inc = pc_q + PC_STEP;

    // next state, word selection, request and PC update
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        buf_d          = buf_q;
        word           = NOP_INSTR;
        word_vld       = 1'b0;
        consume        = 1'b0;
        imem_req_valid = 1'b0;
        imem_req_addr  = pc_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready)
                    state_d = redirect_en ? DRAIN : WAIT;
            end
            WAIT: begin
                imem_req_addr  = pc_inc;
                word           = imem_rsp_data;
                word_vld       = imem_rsp_valid && !redirect_en;
                imem_req_valid = imem_rsp_valid && !stall_IF
                                 && !redirect_en;
                if (redirect_en) begin
                    state_d = imem_rsp_valid ? REQ : DRAIN;
                end else if (imem_rsp_valid) begin
                    if (stall_IF) begin
                        buf_d   = imem_rsp_data;
                        state_d = HOLD;
                    end else begin
                        state_d = imem_req_ready ? WAIT : REQ;
                    end
                end
            end
            HOLD: begin
                word     = buf_q;
                word_vld = !redirect_en;
                if (redirect_en || !stall_IF)
                    state_d = REQ;
            end
            DRAIN: begin
                if (imem_rsp_valid)
                    state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
        consume = word_vld && !stall_IF;
        if (redirect_en) begin
            pc_d  = redirect_pc;
            buf_d = NOP_INSTR;
        end else if (consume) begin
            pc_d = pc_inc;
        end
    end

    // state, PC and held-word registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            buf_q   <= NOP_INSTR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            buf_q   <= buf_d;
        end
    end

    assign INSTR_IF   = word_vld ? word : NOP_INSTR;
    assign PC_IF      = pc_q;
    assign fetch_busy = !word_vld;

`ifdef FETCH_PERF_CNT_EN
    fetch_perf_counter u_perf (
        .clk          (clk),
        .rst          (rst),
        .fetch_inc    (consume),
        .bubble_inc   (!word_vld && !stall_IF),
        .perf_fetched (perf_fetched),
        .perf_bubbles (perf_bubbles)
    );
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage.
// Directed vector table, reset sequence, randomized reference-model run.
module tb_instruction_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_IF;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] INSTR_IF;
    logic [31:0] PC_IF;
    logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    always #5 clk = ~clk;

    instruction_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall_IF       (stall_IF),
        .redirect_en    (redirect_en),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .INSTR_IF       (INSTR_IF),
        .PC_IF          (PC_IF),
        .fetch_busy     (fetch_busy)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    // memory image: injective in the word address, never equal to NOP
    function automatic logic [31:0] img(input logic [31:0] a);
        return {a[31:2] ^ 30'h2A5A5A5A, 2'b10};
    endfunction

    // memory model: one pending response with per-request latency
    logic        pend;
    logic [31:0] pend_addr;
    int          pend_due;
    int          cyc;

    task automatic drive(input logic r, input logic s, input logic re,
                         input logic [31:0] rp, input logic rdy,
                         input int l);
        @(posedge clk);
        #1;
        cyc++;
        rst            = r;
        stall_IF       = s;
        redirect_en    = re;
        redirect_pc    = rp;
        imem_req_ready = rdy;
        if (pend && pend_due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = img(pend_addr);
            pend           = 1'b0;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        if (imem_req_valid && imem_req_ready) begin
            vectors++;
            if (pend) begin
                miscompares++;
                $display("FAIL outstanding: second handshake addr=%h while %h pending",
                         imem_req_addr, pend_addr);
            end
            pend      = 1'b1;
            pend_addr = imem_req_addr;
            pend_due  = cyc + l;
        end
    endtask

    task automatic chk(input string nm, input logic rv,
                       input logic [31:0] ra, input logic bz,
                       input logic [31:0] ins, input logic [31:0] pc);
        vectors++;
        if (imem_req_valid !== rv || (rv && imem_req_addr !== ra) ||
            fetch_busy !== bz || INSTR_IF !== ins || PC_IF !== pc) begin
            miscompares++;
            $display("FAIL %s: got rv=%b addr=%h busy=%b instr=%h pc=%h want rv=%b addr=%h busy=%b instr=%h pc=%h",
                     nm, imem_req_valid, imem_req_addr, fetch_busy,
                     INSTR_IF, PC_IF, rv, ra, bz, ins, pc);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        stall_IF       = 1'b0;
        redirect_en    = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend           = 1'b0;
        @(negedge clk);
        chk("reset", 1'b0, 32'h0, 1'b1, NOP, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        chk("idle0", 1'b0, 32'h0, 1'b1, NOP, 32'h0);
    endtask

    typedef struct {
        logic        s;
        logic        re;
        logic [31:0] rp;
        logic        rdy;
        int          l;
        logic        rv;
        logic [31:0] ra;
        logic        bz;
        logic [31:0] ins;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic re,
                                input logic [31:0] rp, input logic rdy,
                                input int l, input logic rv,
                                input logic [31:0] ra, input logic bz,
                                input logic [31:0] ins,
                                input logic [31:0] pc);
        vec_t v;
        v.s = s; v.re = re; v.rp = rp; v.rdy = rdy; v.l = l;
        v.rv = rv; v.ra = ra; v.bz = bz; v.ins = ins; v.pc = pc;
        return v;
    endfunction

    vec_t tv[32];

    initial begin
        logic        s, re, rdy, vld, cons, bad;
        logic        prev_hold, prev_req;
        logic [31:0] rp, exp_pc, prev_instr, prev_addr;
        int          l, n_cons;
`ifdef FETCH_PERF_CNT_EN
        logic [31:0] m_f, m_b;
`endif

        // stall, redirect, rpc, ready, lat | rv, addr, busy, instr, pc
        tv[0]  = mk(0,0,0,1,1, 1,32'h0,1,NOP,32'h0);
        tv[1]  = mk(0,0,0,1,1, 1,32'h4,0,img(32'h0),32'h0);
        tv[2]  = mk(0,0,0,1,1, 1,32'h8,0,img(32'h4),32'h4);
        tv[3]  = mk(1,0,0,1,1, 0,32'h0,0,img(32'h8),32'h8);
        tv[4]  = mk(1,0,0,1,1, 0,32'h0,0,img(32'h8),32'h8);
        tv[5]  = mk(1,0,0,1,1, 0,32'h0,0,img(32'h8),32'h8);
        tv[6]  = mk(0,0,0,1,1, 0,32'h0,0,img(32'h8),32'h8);
        tv[7]  = mk(0,0,0,1,1, 1,32'hC,1,NOP,32'hC);
        tv[8]  = mk(0,0,0,1,1, 1,32'h10,0,img(32'hC),32'hC);
        tv[9]  = mk(1,1,32'h200,1,1, 0,32'h0,1,NOP,32'h10);
        tv[10] = mk(0,0,0,1,3, 1,32'h200,1,NOP,32'h200);
        tv[11] = mk(0,0,0,1,1, 0,32'h0,1,NOP,32'h200);
        tv[12] = mk(0,1,32'h100,1,1, 0,32'h0,1,NOP,32'h200);
        tv[13] = mk(0,0,0,1,1, 0,32'h0,1,NOP,32'h100);
        tv[14] = mk(0,0,0,1,1, 1,32'h100,1,NOP,32'h100);
        tv[15] = mk(0,0,0,1,1, 1,32'h104,0,img(32'h100),32'h100);
        tv[16] = mk(0,0,0,0,1, 1,32'h108,0,img(32'h104),32'h104);
        tv[17] = mk(0,0,0,0,1, 1,32'h108,1,NOP,32'h108);
        tv[18] = mk(0,0,0,0,1, 1,32'h108,1,NOP,32'h108);
        tv[19] = mk(0,0,0,0,1, 1,32'h108,1,NOP,32'h108);
        tv[20] = mk(0,0,0,0,1, 1,32'h108,1,NOP,32'h108);
        tv[21] = mk(0,0,0,1,1, 1,32'h108,1,NOP,32'h108);
        tv[22] = mk(0,0,0,1,1, 1,32'h10C,0,img(32'h108),32'h108);
        tv[23] = mk(1,0,0,1,1, 0,32'h0,0,img(32'h10C),32'h10C);
        tv[24] = mk(0,1,32'h300,1,1, 0,32'h0,1,NOP,32'h10C);
        tv[25] = mk(0,0,0,1,1, 1,32'h300,1,NOP,32'h300);
        tv[26] = mk(0,0,0,1,1, 1,32'h304,0,img(32'h300),32'h300);
        tv[27] = mk(0,1,32'hFFFF_FFF8,1,1, 0,32'h0,1,NOP,32'h304);
        tv[28] = mk(0,0,0,1,1, 1,32'hFFFF_FFF8,1,NOP,32'hFFFF_FFF8);
        tv[29] = mk(0,0,0,1,1, 1,32'hFFFF_FFFC,0,img(32'hFFFF_FFF8),
                    32'hFFFF_FFF8);
        tv[30] = mk(0,0,0,1,1, 1,32'h0,0,img(32'hFFFF_FFFC),
                    32'hFFFF_FFFC);
        tv[31] = mk(0,0,0,1,1, 1,32'h4,0,img(32'h0),32'h0);

        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, tv[i].s, tv[i].re, tv[i].rp, tv[i].rdy, tv[i].l);
            chk($sformatf("vec%0d", i + 1), tv[i].rv, tv[i].ra,
                tv[i].bz, tv[i].ins, tv[i].pc);
        end

        // asynchronous reset while a slow response is in flight
        do_reset();
        drive(1, 0, 0, 0, 1, 1);
        chk("rs_req", 1, 32'h0, 1, NOP, 32'h0);
        drive(1, 0, 0, 0, 1, 1);
        chk("rs_w0", 1, 32'h4, 0, img(32'h0), 32'h0);
        drive(1, 0, 0, 0, 1, 3);
        chk("rs_w4", 1, 32'h8, 0, img(32'h4), 32'h4);
        drive(1, 0, 0, 0, 1, 1);
        chk("rs_wait", 0, 32'h0, 1, NOP, 32'h8);
        #1 rst = 1'b0;
        #1 chk("rs_async", 0, 32'h0, 1, NOP, 32'h0);
        drive(0, 0, 0, 0, 1, 1);
        chk("rs_low", 0, 32'h0, 1, NOP, 32'h0);
        drive(1, 0, 0, 0, 1, 1);
        chk("rs_late", 0, 32'h0, 1, NOP, 32'h0);
        drive(1, 0, 0, 0, 1, 1);
        chk("rs_restart", 1, 32'h0, 1, NOP, 32'h0);
        drive(1, 0, 0, 0, 1, 1);
        chk("rs_first", 1, 32'h4, 0, img(32'h0), 32'h0);

        // randomized run against the architectural fetch-stream model
        do_reset();
        exp_pc     = 32'h0;
        prev_hold  = 1'b0;
        prev_req   = 1'b0;
        prev_instr = '0;
        prev_addr  = '0;
        n_cons     = 0;
`ifdef FETCH_PERF_CNT_EN
        m_f = 32'd0;
        m_b = 32'd1;
`endif
        for (int k = 0; k < 3000; k++) begin
            s   = ($urandom_range(3) == 0);
            re  = ($urandom_range(9) == 0);
            rp  = $urandom & 32'hFFFF_FFFC;
            rdy = ($urandom_range(9) < 7);
            l   = $urandom_range(4, 1);
            drive(1'b1, s, re, rp, rdy, l);
            vld  = !fetch_busy;
            cons = vld && !s && !re;
            bad  = 1'b0;
            if (PC_IF !== exp_pc) bad = 1'b1;
            if (vld && INSTR_IF !== img(exp_pc)) bad = 1'b1;
            if (!vld && INSTR_IF !== NOP) bad = 1'b1;
            if (re && vld) bad = 1'b1;
            if (prev_hold && !re && !(vld && INSTR_IF == prev_instr))
                bad = 1'b1;
            if (imem_req_valid &&
                imem_req_addr !== exp_pc + (cons ? 32'd4 : 32'd0))
                bad = 1'b1;
            if (prev_req &&
                !(imem_req_valid && imem_req_addr == prev_addr))
                bad = 1'b1;
`ifdef FETCH_PERF_CNT_EN
            if (perf_fetched !== m_f || perf_bubbles !== m_b) bad = 1'b1;
            if (cons) m_f = m_f + 32'd1;
            if (fetch_busy && !s) m_b = m_b + 32'd1;
`endif
            vectors++;
            if (bad) begin
                miscompares++;
                $display("FAIL rand%0d: got pc=%h instr=%h busy=%b rv=%b addr=%h want pc=%h instr=%h",
                         k, PC_IF, INSTR_IF, fetch_busy, imem_req_valid,
                         imem_req_addr, exp_pc, img(exp_pc));
            end
            prev_hold  = vld && s && !re;
            prev_instr = INSTR_IF;
            prev_req   = imem_req_valid && !rdy && !re;
            prev_addr  = imem_req_addr;
            if (re)
                exp_pc = rp;
            else if (cons)
                exp_pc = exp_pc + 32'd4;
            if (cons) n_cons++;
        end
        vectors++;
        if (n_cons < 100) begin
            miscompares++;
            $display("FAIL progress: got %0d consumed fetches, want >= 100",
                     n_cons);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
